// File: rtl/writeback_stage_pipe.sv
// writeback_stage_pipe
//   MEM/WB pipeline register with valid/stall/flush control, load-data
//   alignment and sign/zero extension, four-way result select, and the
//   register-file write port plus a one-cycle retire pulse.
//
//   Optional feature: define WB_INSTRET_EN to add the 64-bit InstretW
//   retired-instruction counter. Without it the port and counter are absent.
//
// Parameters
//   XLEN       datapath width, 32 or 64 (64 enables LD/LWU)
//   RESET_PC4  reset value of the registered PC+4
//
// Ports
//   clk, rst                      clock, async active-low reset
//   ValidM, StallW, FlushW        M-stage valid, WB hold, WB kill
//   RegWriteM, RdM, ResultSrcM    write enable, rd, result source (M stage)
//   Funct3M                       load size/sign
//   ALU_ResultM, ReadDataM        ALU result / load address, raw memory word
//   PCPlus4M, ImmExtM             PC+4, extended immediate
//   ValidW, RegWriteW, RdW        WB valid, register-file write enable/addr
//   ResultW                       register-file write data
//   RetireW                       one pulse per retired instruction
//   InstretW                      retire count (WB_INSTRET_EN only)
//   LoadErrW                      illegal load funct3 for this XLEN
module writeback_stage_pipe #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC4 = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidM,
    input  logic            StallW,
    input  logic            FlushW,
    input  logic            RegWriteM,
    input  logic [4:0]      RdM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] ReadDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] ImmExtM,
    output logic            ValidW,
    output logic            RegWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ResultW,
    output logic            RetireW,
`ifdef WB_INSTRET_EN
    output logic [63:0]     InstretW,
`endif
    output logic            LoadErrW
);
    // Byte-lane offset width within one XLEN word.
    localparam int OFFW = $clog2(XLEN/8);

    typedef struct packed {
        logic            regwrite;
        logic [4:0]      rd;
        logic [1:0]      src;
        logic [2:0]      f3;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] imm;
    } wb_t;

    wb_t  wb_d, wb_q;
    logic valid_q;

    always_comb begin
        wb_d          = '0;
        wb_d.regwrite = RegWriteM;
        wb_d.rd       = RdM;
        wb_d.src      = ResultSrcM;
        wb_d.f3       = Funct3M;
        wb_d.alu      = ALU_ResultM;
        wb_d.rdata    = ReadDataM;
        wb_d.pc4      = PCPlus4M;
        wb_d.imm      = ImmExtM;
    end

    // Flush beats stall. On flush the payload still loads; only valid is
    // killed, which gates the write and retire downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            wb_q       <= '0;
            wb_q.pc4   <= RESET_PC4;
        end else if (FlushW) begin
            valid_q    <= 1'b0;
            wb_q       <= wb_d;
        end else if (!StallW) begin
            valid_q    <= ValidM;
            wb_q       <= wb_d;
        end
    end

    // Load alignment: halfword/word offsets drop the low offset bits so a
    // misaligned address still selects the naturally aligned container.
    logic [OFFW-1:0] off, off_h, off_w;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_w;
    logic [XLEN-1:0] ld_data;
    logic            ld_illegal;

    assign off   = wb_q.alu[OFFW-1:0];
    assign off_h = off & ~OFFW'(1);
    assign off_w = off & ~OFFW'(3);
    assign ld_b  = 8'(wb_q.rdata  >> {off,   3'b000});
    assign ld_h  = 16'(wb_q.rdata >> {off_h, 3'b000});
    assign ld_w  = 32'(wb_q.rdata >> {off_w, 3'b000});

    always_comb begin
        ld_data    = '0;
        ld_illegal = 1'b0;
        case (wb_q.f3)
            3'b000:  ld_data = XLEN'($signed(ld_b));
            3'b100:  ld_data = XLEN'(ld_b);
            3'b001:  ld_data = XLEN'($signed(ld_h));
            3'b101:  ld_data = XLEN'(ld_h);
            3'b010:  ld_data = XLEN'($signed(ld_w));
            3'b110: begin
                if (XLEN == 64) ld_data    = XLEN'(ld_w);
                else            ld_illegal = 1'b1;
            end
            3'b011: begin
                if (XLEN == 64) ld_data    = wb_q.rdata;
                else            ld_illegal = 1'b1;
            end
            default: ld_illegal = 1'b1;
        endcase
    end

    always_comb begin
        ResultW = wb_q.alu;
        case (wb_q.src)
            2'b00:   ResultW = wb_q.alu;
            2'b01:   ResultW = ld_data;
            2'b10:   ResultW = wb_q.pc4;
            default: ResultW = wb_q.imm;
        endcase
    end

    assign ValidW    = valid_q;
    assign RdW       = wb_q.rd;
    assign LoadErrW  = valid_q & (wb_q.src == 2'b01) & ld_illegal;
    // x0 is never written; a faulting load never writes.
    assign RegWriteW = valid_q & wb_q.regwrite & (wb_q.rd != 5'd0) & ~LoadErrW;
    // A stalled instruction keeps RegWriteW high (idempotent) but retires
    // only in the cycle the stall drops.
    assign RetireW   = valid_q & ~StallW;

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         InstretW <= '0;
        else if (RetireW) InstretW <= InstretW + 64'd1;
    end
`endif

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Directed, scoreboard-checked bench for writeback_stage_pipe.
// Two instances share control: u32 (XLEN=32, nonzero RESET_PC4) and u64.
module tb_writeback_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, StallW, FlushW, RegWriteM;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [63:0] ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM;

    logic        v32, rw32, ret32, le32;
    logic [4:0]  rd32;
    logic [31:0] res32;
    logic        v64, rw64, ret64, le64;
    logic [4:0]  rd64;
    logic [63:0] res64;
`ifdef WB_INSTRET_EN
    logic [63:0] ir32, ir64;
`endif

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    typedef struct {
        logic        is64;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        regw;
        logic        lerr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    writeback_stage_pipe #(.XLEN(32), .RESET_PC4(32'h0000_1234)) u32 (
        .clk(clk), .rst(rst), .ValidM(ValidM), .StallW(StallW), .FlushW(FlushW),
        .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .ALU_ResultM(ALU_ResultM[31:0]), .ReadDataM(ReadDataM[31:0]),
        .PCPlus4M(PCPlus4M[31:0]), .ImmExtM(ImmExtM[31:0]),
        .ValidW(v32), .RegWriteW(rw32), .RdW(rd32), .ResultW(res32), .RetireW(ret32),
`ifdef WB_INSTRET_EN
        .InstretW(ir32),
`endif
        .LoadErrW(le32)
    );

    writeback_stage_pipe #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .ValidM(ValidM), .StallW(StallW), .FlushW(FlushW),
        .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM),
        .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .ValidW(v64), .RegWriteW(rw64), .RdW(rd64), .ResultW(res64), .RetireW(ret64),
`ifdef WB_INSTRET_EN
        .InstretW(ir64),
`endif
        .LoadErrW(le64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_wb(input string tag, input exp_t e, input logic eret);
        logic        v, rw, rt, le;
        logic [4:0]  rd;
        logic [63:0] res;
        if (e.is64) begin
            v = v64; rw = rw64; rt = ret64; le = le64; rd = rd64; res = res64;
        end else begin
            v = v32; rw = rw32; rt = ret32; le = le32; rd = rd32; res = {32'b0, res32};
        end
        chk({tag, ".valid"},  64'(v),  64'd1);
        chk({tag, ".rd"},     64'(rd), 64'(e.rd));
        chk({tag, ".result"}, res,     e.res);
        chk({tag, ".regw"},   64'(rw), 64'(e.regw));
        chk({tag, ".lerr"},   64'(le), 64'(e.lerr));
        chk({tag, ".retire"}, 64'(rt), 64'(eret));
    endtask

    // Drive one instruction, push its expectation, compare one cycle later.
    // The following edge always has StallW=0, so it retires there.
    task automatic issue(input string tag, input logic is64, input logic rw,
                         input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                         input logic [63:0] alu, input logic [63:0] rdat,
                         input logic [63:0] pc4, input logic [63:0] imm,
                         input logic [63:0] eres, input logic eregw, input logic elerr);
        exp_t e;
        ValidM = 1'b1; StallW = 1'b0; FlushW = 1'b0; RegWriteM = rw;
        RdM = rd; ResultSrcM = src; Funct3M = f3;
        ALU_ResultM = alu; ReadDataM = rdat; PCPlus4M = pc4; ImmExtM = imm;
        sb.push_back('{is64, rd, eres, eregw, elerr});
        @(posedge clk); #1;
        e = sb.pop_front();
        check_wb(tag, e, 1'b1);
        exp_ret++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".v32"},   64'(v32),   64'd0);
        chk({tag, ".rw32"},  64'(rw32),  64'd0);
        chk({tag, ".rd32"},  64'(rd32),  64'd0);
        chk({tag, ".res32"}, 64'(res32), 64'd0);
        chk({tag, ".ret32"}, 64'(ret32), 64'd0);
        chk({tag, ".le32"},  64'(le32),  64'd0);
        chk({tag, ".v64"},   64'(v64),   64'd0);
        chk({tag, ".res64"}, res64,      64'd0);
`ifdef WB_INSTRET_EN
        chk({tag, ".ir32"},  ir32,       64'd0);
        chk({tag, ".ir64"},  ir64,       64'd0);
`endif
    endtask

    initial begin
        exp_t e;
        rst = 1'b0; ValidM = 1'b0; StallW = 1'b0; FlushW = 1'b0; RegWriteM = 1'b0;
        RdM = '0; ResultSrcM = '0; Funct3M = '0;
        ALU_ResultM = '0; ReadDataM = '0; PCPlus4M = '0; ImmExtM = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;

        //     tag          64 rw rd     src    f3      alu    rdata                   pc4    imm           expected                regw lerr
        issue("alu",        0, 1, 5'd5, 2'b00, 3'b000, 64'h3, 64'h0,                  64'h0, 64'h0,        64'h3,                  1, 0);
        issue("lb_off1",    0, 1, 5'd6, 2'b01, 3'b000, 64'h1, 64'h80FF7F01,           64'h0, 64'h0,        64'h7F,                 1, 0);
        issue("lb_off2",    0, 1, 5'd6, 2'b01, 3'b000, 64'h2, 64'h80FF7F01,           64'h0, 64'h0,        64'hFFFFFFFF,           1, 0);
        issue("lhu_off2",   0, 1, 5'd6, 2'b01, 3'b101, 64'h2, 64'h80FF7F01,           64'h0, 64'h0,        64'h000080FF,           1, 0);
        issue("lh_off2",    0, 1, 5'd6, 2'b01, 3'b001, 64'h2, 64'h80FF7F01,           64'h0, 64'h0,        64'hFFFF80FF,           1, 0);
        issue("lh_off3",    0, 1, 5'd6, 2'b01, 3'b001, 64'h3, 64'h80FF7F01,           64'h0, 64'h0,        64'hFFFF80FF,           1, 0);
        issue("lw_off3",    0, 1, 5'd6, 2'b01, 3'b010, 64'h3, 64'h80FF7F01,           64'h0, 64'h0,        64'h80FF7F01,           1, 0);
        issue("pc4",        0, 1, 5'd4, 2'b10, 3'b000, 64'h77, 64'h55,                64'h2, 64'h99,       64'h2,                  1, 0);
        issue("imm",        0, 1, 5'd4, 2'b11, 3'b000, 64'h77, 64'h55,                64'h2, 64'hABCDE000, 64'hABCDE000,           1, 0);
        issue("x0",         0, 1, 5'd0, 2'b00, 3'b000, 64'h55, 64'h0,                 64'h0, 64'h0,        64'h55,                 0, 0);
        issue("norw",       0, 0, 5'd8, 2'b00, 3'b000, 64'h66, 64'h0,                 64'h0, 64'h0,        64'h66,                 0, 0);
        issue("ld_111",     0, 1, 5'd7, 2'b01, 3'b111, 64'h0, 64'h80FF7F01,           64'h0, 64'h0,        64'h0,                  0, 1);
        issue("ld_011_32",  0, 1, 5'd7, 2'b01, 3'b011, 64'h0, 64'h80FF7F01,           64'h0, 64'h0,        64'h0,                  0, 1);
        issue("alu_f3_111", 0, 1, 5'd7, 2'b00, 3'b111, 64'h9, 64'h80FF7F01,           64'h0, 64'h0,        64'h9,                  1, 0);
        issue("ld64",       1, 1, 5'd3, 2'b01, 3'b011, 64'h0, 64'h8000000000000001,   64'h0, 64'h0,        64'h8000000000000001,   1, 0);
        issue("lwu64_off4", 1, 1, 5'd3, 2'b01, 3'b110, 64'h4, 64'hFFFFFFFF00000000,   64'h0, 64'h0,        64'h00000000FFFFFFFF,   1, 0);
        issue("lw64_off4",  1, 1, 5'd3, 2'b01, 3'b010, 64'h4, 64'hFFFFFFFF00000000,   64'h0, 64'h0,        64'hFFFFFFFFFFFFFFFF,   1, 0);
        issue("lb64_off7",  1, 1, 5'd3, 2'b01, 3'b000, 64'h7, 64'h8000000000000001,   64'h0, 64'h0,        64'hFFFFFFFFFFFFFF80,   1, 0);
        issue("lhu64_off6", 1, 1, 5'd3, 2'b01, 3'b101, 64'h6, 64'h8000000000000001,   64'h0, 64'h0,        64'h8000,               1, 0);

        // Stall: A enters WB, then is held for three edges while B waits in M.
        ValidM = 1'b1; RegWriteM = 1'b1; RdM = 5'd9; ResultSrcM = 2'b00; Funct3M = 3'b000;
        ALU_ResultM = 64'h11;
        sb.push_back('{1'b0, 5'd9, 64'h11, 1'b1, 1'b0});
        @(posedge clk); #1;
        StallW = 1'b1; RdM = 5'd10; ALU_ResultM = 64'h22;
        sb.push_back('{1'b0, 5'd10, 64'h22, 1'b1, 1'b0});
        #1;
        for (int i = 0; i < 3; i++) begin
            check_wb($sformatf("stall%0d", i), sb[0], 1'b0);
            @(posedge clk); #1;
        end
        check_wb("stall3", sb[0], 1'b0);
        StallW = 1'b0; #1;
        e = sb.pop_front();
        check_wb("stall_release", e, 1'b1);
        exp_ret++;
        @(posedge clk); #1;
        e = sb.pop_front();
        check_wb("after_stall", e, 1'b1);
        exp_ret++;
        ValidM = 1'b0;
        @(posedge clk); #1;
        chk("bubble.valid", 64'(v32), 64'd0);

        // Flush together with stall over a valid instruction in WB.
        ValidM = 1'b1; RdM = 5'd11; ALU_ResultM = 64'h33;
        @(posedge clk); #1;
        FlushW = 1'b1; StallW = 1'b1; RdM = 5'd12; ALU_ResultM = 64'h44; #1;
        chk("flush_pre.retire", 64'(ret32), 64'd0);
        @(posedge clk); #1;
        chk("flush.valid",  64'(v32),  64'd0);
        chk("flush.regw",   64'(rw32), 64'd0);
        chk("flush.retire", 64'(ret32), 64'd0);
        FlushW = 1'b0; StallW = 1'b0; ValidM = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset with an instruction in WB discards it.
        ValidM = 1'b1; RdM = 5'd13; ALU_ResultM = 64'h55;
        @(posedge clk); #1;
        chk("pre_reset.regw", 64'(rw32), 64'd1);
        rst = 1'b0; #1;
        check_reset("mid_reset");
        exp_ret = 0;
        ValidM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            issue($sformatf("ret%0d", i), 0, 1, 5'(i + 1), 2'b00, 3'b000,
                  64'(i * 3 + 1), 64'h0, 64'h0, 64'h0, 64'(i * 3 + 1), 1, 0);
        ValidM = 1'b0;
        @(posedge clk); #1;
`ifdef WB_INSTRET_EN
        chk("instret32", ir32, 64'(exp_ret));
        chk("instret64", ir64, 64'(exp_ret));
`endif
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_stage_pipe.md
Name: writeback_stage_pipe

Overview:
- Parametrised successor to the single-cycle writeback mux.
- Adds the MEM/WB pipeline register with valid, stall and flush control.
- Extracts, aligns and sign- or zero-extends load data, and selects among four result sources.
- Drives the register-file write port (RegWriteW/RdW/ResultW) plus a one-cycle retire pulse. Sits between the memory stage and the register file / hazard unit.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64 only (64 enables LD/LWU).
- RESET_PC4, 0, reset value of the internal PCPlus4 register; not externally visible except via ResultW.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ValidM  in  1  M-stage holds a real instruction
- StallW  in  1  hold the WB register contents
- FlushW  in  1  kill the instruction entering WB
- RegWriteM  in  1  instruction writes rd
- RdM  in  5  destination register
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- Funct3M  in  3  load size/sign
- ALU_ResultM  in  XLEN  ALU result / load address
- ReadDataM  in  XLEN  raw data-memory word
- PCPlus4M  in  XLEN  PC+4
- ImmExtM  in  XLEN  extended immediate
- ValidW  out  1  WB holds a real instruction
- RegWriteW  out  1  register-file write enable
- RdW  out  5  register-file write address
- ResultW  out  XLEN  register-file write data
- RetireW  out  1  one-cycle pulse per retired instruction
- LoadErrW  out  1  illegal load funct3 for this XLEN

Behaviour:
- Reset (rst=0, asynchronous): all WB registers are 0, so ValidW=0, RegWriteW=0, RdW=0, ResultW=0, RetireW=0 and LoadErrW=0.
  - Exception: the PCPlus4 register resets to RESET_PC4. ResultW is still 0 because the registered ResultSrc resets to 00 and the registered ALU result is 0.
- Reset mid-operation discards the in-flight instruction; no write occurs.
- Capture happens at each posedge clk:
  - FlushW=1: ValidW<=0; the other fields may load, but the write is gated off. FlushW has priority over StallW.
  - Else StallW=1: all WB registers hold their value.
  - Else: all M-stage inputs are registered and ValidW<=ValidM.
- Latency: exactly 1 cycle from M inputs to WB outputs.
- Load extraction is combinational on the registered fields.
  - Lane offset = ALU_ResultW[log2(XLEN/8)-1:0].
  - LB/LBU (000/100): byte at offset*8.
  - LH/LHU (001/101): halfword at (offset>>1)*16; offset bit 0 is ignored.
  - LW (010): word at (offset>>2)*32 (0 when XLEN=32).
  - LWU (110), XLEN=64 only: word, zero-extended.
  - LD (011), XLEN=64 only: full 64-bit word.
  - Signed forms sign-extend to XLEN; U forms zero-extend.
  - Illegal funct3 (111 always; 011/110 when XLEN=32) with ResultSrc=01: load data=0 and LoadErrW=ValidW. Otherwise LoadErrW=0.
- Result mux: 00 ALU_ResultW, 01 extracted load, 10 PCPlus4W, 11 ImmExtW.
- RegWriteW = ValidW & RegWriteReg & (RdW != 0) & ~LoadErrW. A write to x0 is never issued.
- RetireW = ValidW & ~StallW, for exactly one cycle per instruction. A stalled instruction retires only on the cycle StallW deasserts.
- Stall held for N cycles: RegWriteW stays asserted the whole time, which is idempotent for the register file. RetireW fires once.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: adds output InstretW (64 bits), a counter that resets to 0 on rst=0 and increments by 1 on every cycle RetireW=1. It wraps from 2^64-1 to 0. It is not affected by FlushW except through RetireW.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset and ALU path: rst=0 for 2 cycles, then rst=1. Apply ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALU_ResultM=0x3 -> next cycle ResultW=0x3, RdW=5, RegWriteW=1, RetireW=1.
- Load sign/zero: ReadDataM=0x80FF7F01, ALU_ResultM=0x1, ResultSrcM=01.
  - Funct3M=000 -> ResultW=0x0000007F.
  - ALU_ResultM=0x2, Funct3M=000 -> ResultW=0xFFFFFFFF.
  - ALU_ResultM=0x2, Funct3M=101 -> ResultW=0x000080FF.
  - ALU_ResultM=0x2, Funct3M=001 -> ResultW=0xFFFF80FF.
- PC+4 and immediate: ResultSrcM=10, PCPlus4M=0x2 -> ResultW=0x2. ResultSrcM=11, ImmExtM=0xABCDE000 -> ResultW=0xABCDE000.
- x0 and illegal load: RdM=0, RegWriteM=1 -> RegWriteW=0. Funct3M=111, ResultSrcM=01 -> LoadErrW=1, RegWriteW=0, ResultW=0.
- Stall/flush: hold StallW=1 for 3 cycles -> outputs frozen and one RetireW pulse at release. Assert FlushW=1 and StallW=1 together -> ValidW=0 and RegWriteW=0 next cycle.
- XLEN=64 with WB_INSTRET_EN: LD of 0x8000000000000001 -> ResultW unchanged. LWU at offset 4 of 0xFFFFFFFF00000000 -> 0x00000000FFFFFFFF. After 10 retires, InstretW=10.
